gpsreceiver2_capture: RTL and testbench

Capture sequencer and sample packer for the GPS-SDR receive path. It takes 2-bit sign/magnitude samples from the RF front-end interface and packs 16 samples into each 32-bit word. Each completed word is written into the 2048-word receive sample buffer, together with its address and a one-cycle write enable. It also reports progress, completion and an interrupt pulse to the control/CSR block. Optionally, the start of capture is aligned to a PPS edge.

---
 rtl/gpsreceiver2_capture_if.sv | 31 +++
 rtl/gpsreceiver2_capture.sv | 116 +++++++++++
 tb/tb_gpsreceiver2_capture.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpsreceiver2_capture_if.sv
// Signal bundle between the front-end/control side and the capture sequencer.
// The master drives samples and control requests; the slave returns buffer writes and status.
interface gpsreceiver2_capture_if;
    logic        sample_en;
    logic        sample_sign;
    logic        sample_mag;
    logic        pps;
    logic        r_start;
    logic        r_abort;
    logic        r_trig_mode;
    logic [10:0] r_length;
    logic        rxb0_we;
    logic [10:0] rxb0_adr;
    logic [31:0] rxb0_dat;
    logic [10:0] rx_count;
    logic        r_busy;
    logic        r_done;
    logic        irq;

    modport master (
        output sample_en, sample_sign, sample_mag, pps,
        output r_start, r_abort, r_trig_mode, r_length,
        input  rxb0_we, rxb0_adr, rxb0_dat, rx_count, r_busy, r_done, irq
    );

    modport slave (
        input  sample_en, sample_sign, sample_mag, pps,
        input  r_start, r_abort, r_trig_mode, r_length,
        output rxb0_we, rxb0_adr, rxb0_dat, rx_count, r_busy, r_done, irq
    );
endinterface

// File: rtl/gpsreceiver2_capture.sv
// GPS-SDR capture sequencer: packs 16 two-bit samples per 32-bit word into the receive buffer,
// with optional PPS-aligned start, abort, and completion status/interrupt.
module gpsreceiver2_capture (
    input logic                   rxb0_clk,
    input logic                   rxb0_rst_n,
    gpsreceiver2_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t      state_q;
    logic        ppsPrev_q;
    logic [3:0]  slot_q;
    logic [31:0] pack_q;
    logic [10:0] wordIdx_q;
    logic [10:0] lastIdx_q;
    logic        we_q;
    logic [10:0] adr_q;
    logic [31:0] dat_q;
    logic [10:0] count_q;
    logic        busy_q;
    logic        done_q;
    logic        irq_q;

    logic [31:0] pack_d;
    logic        ppsRise;
    logic        startReq;
    logic        finalWrite;

    always_comb begin
        pack_d                  = pack_q;
        pack_d[{slot_q, 1'b1}]  = bus.sample_sign;
        pack_d[{slot_q, 1'b0}]  = bus.sample_mag;
        ppsRise                 = bus.pps & ~ppsPrev_q;
        startReq                = bus.r_start & ~bus.r_abort;
        finalWrite              = we_q && (adr_q == lastIdx_q);
    end

    // A length of 0 wraps to lastIdx 2047, which is exactly the 2048-word capture.
    always_ff @(posedge rxb0_clk) begin
        if (!rxb0_rst_n) begin
            state_q   <= IDLE;
            ppsPrev_q <= 1'b0;
            slot_q    <= 4'd0;
            pack_q    <= 32'd0;
            wordIdx_q <= 11'd0;
            lastIdx_q <= 11'd0;
            we_q      <= 1'b0;
            adr_q     <= 11'd0;
            dat_q     <= 32'd0;
            count_q   <= 11'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ppsPrev_q <= bus.pps;
            we_q      <= 1'b0;
            irq_q     <= 1'b0;
            if (we_q) begin
                wordIdx_q <= wordIdx_q + 11'd1;
                count_q   <= count_q + 11'd1;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (startReq) begin
                        state_q   <= bus.r_trig_mode ? ARM : CAPTURE;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        count_q   <= 11'd0;
                        slot_q    <= 4'd0;
                        pack_q    <= 32'd0;
                        wordIdx_q <= 11'd0;
                        lastIdx_q <= bus.r_length - 11'd1;
                    end
                end
                ARM: begin
                    if (bus.r_abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (ppsRise) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.r_abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        slot_q  <= 4'd0;
                    end else if (finalWrite) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;
                    end else if (bus.sample_en) begin
                        // Slot 15 wraps to 0, so a strobe in the write cycle starts the next word.
                        pack_q <= pack_d;
                        slot_q <= slot_q + 4'd1;
                        if (slot_q == 4'd15) begin
                            we_q  <= 1'b1;
                            adr_q <= wordIdx_q;
                            dat_q <= pack_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rxb0_we  = we_q;
    assign bus.rxb0_adr = adr_q;
    assign bus.rxb0_dat = dat_q;
    assign bus.rx_count = count_q;
    assign bus.r_busy   = busy_q;
    assign bus.r_done   = done_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_gpsreceiver2_capture.sv
// Directed/randomized bench for gpsreceiver2_capture; expected words come from a sample-queue model
// that packs each group of 16 recorded samples arithmetically.
module tb_gpsreceiver2_capture;
    logic clk = 1'b0;
    logic rstN = 1'b0;

    gpsreceiver2_capture_if bus();

    gpsreceiver2_capture dut (
        .rxb0_clk   (clk),
        .rxb0_rst_n (rstN),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int passCount = 0;
    int checkCount = 0;
    int cycle = 0;
    int irqCount = 0;
    int irqCycle = 0;
    logic [10:0] wrAdr[$];
    logic [31:0] wrDat[$];
    int          wrCycle[$];
    logic [1:0]  modelSamples[$];
    logic [1:0]  savedSeq[$];
    logic [31:0] contDat[$];

    // Write/irq monitor, sampled half a cycle after the active edge.
    always @(negedge clk) begin
        cycle++;
        if (bus.rxb0_we === 1'b1) begin
            wrAdr.push_back(bus.rxb0_adr);
            wrDat.push_back(bus.rxb0_dat);
            wrCycle.push_back(cycle);
        end
        if (bus.irq === 1'b1) begin
            irqCount++;
            irqCycle = cycle;
        end
    end

    function automatic logic [31:0] modelWord(input int w);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 16; k++)
            r = r | (32'(modelSamples[w * 16 + k]) << (2 * k));
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLogs();
        wrAdr.delete();
        wrDat.delete();
        wrCycle.delete();
        modelSamples.delete();
        irqCount = 0;
    endtask

    task automatic pulseStart(input logic trig, input logic [10:0] len);
        @(negedge clk);
        bus.r_trig_mode = trig;
        bus.r_length    = len;
        bus.r_start     = 1'b1;
        @(negedge clk);
        bus.r_start     = 1'b0;
    endtask

    task automatic pulseAbort();
        bus.r_abort = 1'b1;
        @(negedge clk);
        bus.r_abort = 1'b0;
    endtask

    // mode 0 = random samples, 1 = cycling 00/01/10/11, 2 = replay savedSeq
    task automatic applyStimulus(input int n, input int gap, input int mode, input bit record);
        logic [1:0] s;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       s = 2'($urandom_range(0, 3));
                1:       s = 2'(i % 4);
                default: s = savedSeq[i];
            endcase
            bus.sample_en   = 1'b1;
            bus.sample_sign = s[1];
            bus.sample_mag  = s[0];
            if (record) modelSamples.push_back(s);
            @(negedge clk);
            bus.sample_en = 1'b0;
            for (int g = 1; g < gap; g++) @(negedge clk);
        end
    endtask

    task automatic checkWrites(input string tag, input int n);
        checkOutput($sformatf("%s write count", tag), 32'(wrAdr.size()), 32'(n));
        for (int i = 0; i < n && i < wrAdr.size(); i++) begin
            checkOutput($sformatf("%s adr[%0d]", tag, i), 32'(wrAdr[i]), 32'(i));
            checkOutput($sformatf("%s dat[%0d]", tag, i), wrDat[i], modelWord(i));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " we"},    32'(bus.rxb0_we),  32'd0);
        checkOutput({tag, " adr"},   32'(bus.rxb0_adr), 32'd0);
        checkOutput({tag, " dat"},   bus.rxb0_dat,      32'd0);
        checkOutput({tag, " count"}, 32'(bus.rx_count), 32'd0);
        checkOutput({tag, " busy"},  32'(bus.r_busy),   32'd0);
        checkOutput({tag, " done"},  32'(bus.r_done),   32'd0);
        checkOutput({tag, " irq"},   32'(bus.irq),      32'd0);
    endtask

    initial begin
        bus.sample_en   = 1'b0;
        bus.sample_sign = 1'b0;
        bus.sample_mag  = 1'b0;
        bus.pps         = 1'b0;
        bus.r_start     = 1'b0;
        bus.r_abort     = 1'b0;
        bus.r_trig_mode = 1'b0;
        bus.r_length    = 11'd0;

        tick(3);
        checkAllZero("reset");
        rstN = 1'b1;
        tick(2);

        // Immediate mode, fixed pattern, two words
        clearLogs();
        pulseStart(1'b0, 11'd2);
        checkOutput("pat busy after start", 32'(bus.r_busy), 32'd1);
        applyStimulus(32, 1, 1, 1'b1);
        tick(4);
        checkWrites("pat", 2);
        if (wrDat.size() >= 2) begin
            checkOutput("pat dat0 const", wrDat[0], 32'hE4E4E4E4);
            checkOutput("pat dat1 const", wrDat[1], 32'hE4E4E4E4);
            checkOutput("pat irq latency", 32'(irqCycle - wrCycle[1]), 32'd1);
        end
        checkOutput("pat irq count", 32'(irqCount), 32'd1);
        checkOutput("pat rx_count", 32'(bus.rx_count), 32'd2);
        checkOutput("pat done", 32'(bus.r_done), 32'd1);
        checkOutput("pat busy", 32'(bus.r_busy), 32'd0);

        // Continuous random, then the same sequence sparse (every 3rd cycle)
        clearLogs();
        pulseStart(1'b0, 11'd2);
        checkOutput("cont done cleared", 32'(bus.r_done), 32'd0);
        applyStimulus(32, 1, 0, 1'b1);
        tick(4);
        checkWrites("cont", 2);
        savedSeq = modelSamples;
        contDat  = wrDat;
        clearLogs();
        pulseStart(1'b0, 11'd2);
        applyStimulus(32, 3, 2, 1'b1);
        tick(4);
        checkWrites("sparse", 2);
        for (int i = 0; i < 2 && i < wrDat.size() && i < contDat.size(); i++)
            checkOutput($sformatf("sparse vs cont[%0d]", i), wrDat[i], contDat[i]);
        checkOutput("sparse done", 32'(bus.r_done), 32'd1);

        // PPS-aligned start, one word
        clearLogs();
        pulseStart(1'b1, 11'd1);
        checkOutput("pps busy in arm", 32'(bus.r_busy), 32'd1);
        applyStimulus(20, 1, 0, 1'b0);
        bus.pps         = 1'b1;
        bus.sample_en   = 1'b1;
        bus.sample_sign = 1'b1;
        bus.sample_mag  = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
        applyStimulus(16, 1, 0, 1'b1);
        bus.pps = 1'b0;
        tick(4);
        checkWrites("pps", 1);
        checkOutput("pps rx_count", 32'(bus.rx_count), 32'd1);
        checkOutput("pps done", 32'(bus.r_done), 32'd1);
        checkOutput("pps irq count", 32'(irqCount), 32'd1);

        // Abort part-way through word 3 of an 8-word capture
        clearLogs();
        pulseStart(1'b0, 11'd8);
        applyStimulus(58, 1, 0, 1'b1);
        pulseAbort();
        tick(3);
        checkWrites("abort", 3);
        checkOutput("abort rx_count", 32'(bus.rx_count), 32'd3);
        checkOutput("abort done", 32'(bus.r_done), 32'd0);
        checkOutput("abort busy", 32'(bus.r_busy), 32'd0);
        checkOutput("abort irq count", 32'(irqCount), 32'd0);
        pulseStart(1'b0, 11'd8);
        checkOutput("restart clears rx_count", 32'(bus.rx_count), 32'd0);
        checkOutput("restart busy", 32'(bus.r_busy), 32'd1);
        pulseAbort();
        tick(2);

        // r_start while busy is ignored, then reset mid-capture
        clearLogs();
        pulseStart(1'b0, 11'd4);
        applyStimulus(20, 1, 0, 1'b1);
        bus.r_start = 1'b1;
        applyStimulus(1, 1, 0, 1'b1);
        bus.r_start = 1'b0;
        checkOutput("busy-start rx_count kept", 32'(bus.rx_count), 32'd1);
        checkOutput("busy-start still busy", 32'(bus.r_busy), 32'd1);
        applyStimulus(11, 1, 0, 1'b1);
        tick(2);
        checkWrites("busy-start", 2);
        checkOutput("busy-start rx_count", 32'(bus.rx_count), 32'd2);
        applyStimulus(5, 1, 0, 1'b1);
        rstN = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        rstN = 1'b1;
        tick(3);
        checkOutput("midreset no extra write", 32'(wrAdr.size()), 32'd2);
        checkOutput("midreset irq count", 32'(irqCount), 32'd0);

        // Full 2048-word capture (r_length = 0)
        clearLogs();
        pulseStart(1'b0, 11'd0);
        applyStimulus(32768, 1, 0, 1'b1);
        tick(4);
        checkWrites("full", 2048);
        checkOutput("full rx_count wraps", 32'(bus.rx_count), 32'd0);
        checkOutput("full done", 32'(bus.r_done), 32'd1);
        checkOutput("full busy", 32'(bus.r_busy), 32'd0);
        checkOutput("full irq count", 32'(irqCount), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
